bcd_to_bin: RTL and testbench

// - Sequential BCD-to-binary converter; inverse of the display path's binary-to-BCD encoder.
// - Takes NDIG packed BCD digits (units in bits [3:0]) and produces an unsigned binary value.
// - Uses reverse double-dabble: shift right one bit per cycle, then subtract 3 from any digit >= 8.
// - Sits between the keypad/setpoint BCD entry and the binary counter/compare logic; start/busy/done handshake.

---
 rtl/bcd_pkg.sv | 26 ++
 rtl/bcd_digit_rcorr.sv | 23 ++
 rtl/bcd_to_bin.sv | 129 ++++++++++++
 tb/tb_bcd_to_bin.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD constants and state encoding for the BCD conversion blocks.
//
// Contents:
//   BCD_DIG_W   width of one packed BCD digit
//   BCD_MAX     largest legal digit value
//   RDD_THRESH  reverse double-dabble correction threshold
//   RDD_CORR    reverse double-dabble correction amount
//   ST_IDLE/ST_SHIFT/ST_FIN and state_t, the state encoding shared with the encoder side
package bcd_pkg;

    localparam int         BCD_DIG_W  = 4;
    localparam logic [3:0] BCD_MAX    = 4'd9;
    localparam logic [3:0] RDD_THRESH = 4'd8;
    localparam logic [3:0] RDD_CORR   = 4'd3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_FIN   = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT,
        FIN   = ST_FIN
    } state_t;

endpackage

// File: rtl/bcd_digit_rcorr.sv
// Reverse double-dabble digit correction for one BCD digit.
//
// Ports:
//   din   in   4   digit field after the right shift
//   dout  out  4   corrected digit: din-3 when din >= 8, else din
//
// A digit >= 8 after the shift means a "ten" crossed in from the digit above
// and arrived as weight 8; subtracting 3 turns that 8 into the correct 5.
module bcd_digit_rcorr
    import bcd_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    always_comb begin
        dout = din;
        if (din >= RDD_THRESH) begin
            dout = din - RDD_CORR;
        end
    end

endmodule

// File: rtl/bcd_to_bin.sv
// Sequential BCD-to-binary converter (reverse double-dabble).
//
// Ports:
//   clk        in   1         clock, all logic on posedge
//   rst        in   1         synchronous active-high reset; aborts a conversion without done
//   start      in   1         conversion request, sampled only when busy=0 (IDLE or FIN)
//   bcd        in   4*NDIG    packed BCD digits, units in [3:0]; captured on an accepted start
//   bin        out  BIN_W     binary result, held until the next done
//   busy       out  1         high exactly during SHIFT cycles
//   done       out  1         one-cycle pulse, bin/err valid
//   err        out  1         valid with done; 1 = some input digit was > 9
//   state_dbg  out  2         current FSM state encoding
//
// Handshake: a request is accepted on any clock edge where start=1 and busy=0;
// the conversion then runs without further input (start and bcd are ignored
// while busy) and finishes with a single-cycle done pulse. start may be held
// high through the done cycle to chain conversions with no idle gap.
module bcd_to_bin
    import bcd_pkg::*;
#(
    parameter int NDIG  = 4,
    parameter int BIN_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [BCD_DIG_W*NDIG-1:0] bcd,
    output logic [BIN_W-1:0]         bin,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [1:0]               state_dbg
);

    localparam int BCD_W  = BCD_DIG_W * NDIG;
    localparam int WORK_W = BCD_W + BIN_W;
    localparam int CNT_W  = $clog2(BIN_W + 1);

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [WORK_W-1:0]   work;
    logic [WORK_W-1:0]   work_shr;
    logic [WORK_W-1:0]   work_corr;
    logic                bcd_bad;
    logic                last_shift;

    // Any digit above 9 makes the whole input invalid.
    always_comb begin
        bcd_bad = 1'b0;
        for (int k = 0; k < NDIG; k++) begin
            if (bcd[BCD_DIG_W*k +: BCD_DIG_W] > BCD_MAX) begin
                bcd_bad = 1'b1;
            end
        end
    end

    // Binary bits drain out of the BCD field into the low part; only the
    // BCD digit fields need correcting after each shift.
    assign work_shr = work >> 1;
    assign work_corr[BIN_W-1:0] = work_shr[BIN_W-1:0];

    for (genvar g = 0; g < NDIG; g++) begin : g_rcorr
        bcd_digit_rcorr u_rcorr (
            .din  (work_shr [BIN_W + BCD_DIG_W*g +: BCD_DIG_W]),
            .dout (work_corr[BIN_W + BCD_DIG_W*g +: BCD_DIG_W])
        );
    end

    assign last_shift = (cnt == CNT_W'(1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, FIN: begin
                state_nxt = IDLE;
                if (start) begin
                    state_nxt = bcd_bad ? FIN : SHIFT;
                end
            end
            SHIFT: begin
                if (last_shift) begin
                    state_nxt = FIN;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy      = (state == SHIFT);
    assign done      = (state == FIN);
    assign state_dbg = state;

    // bin/err are loaded on the edge that enters FIN so they are already
    // valid while done is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            work  <= '0;
            bin   <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE, FIN: begin
                    if (start) begin
                        if (bcd_bad) begin
                            bin <= '0;
                            err <= 1'b1;
                        end else begin
                            work <= {bcd, {BIN_W{1'b0}}};
                            cnt  <= CNT_W'(BIN_W);
                        end
                    end
                end
                SHIFT: begin
                    work <= work_corr;
                    cnt  <= cnt - CNT_W'(1);
                    if (last_shift) begin
                        bin <= work_corr[BIN_W-1:0];
                        err <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_bin.sv
module tb_bcd_to_bin;

    localparam int NDIG  = 4;
    localparam int BIN_W = 16;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] bcd;
    logic [15:0] bin;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  state_dbg;

    int tests;
    int fails;
    logic [15:0] last_bin;

    bcd_to_bin #(.NDIG(NDIG), .BIN_W(BIN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bcd       (bcd),
        .bin       (bin),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] bcd;
        logic [15:0] bin;
        logic        err;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // One conversion: start is high for exactly one accepting edge. With junk=1,
    // start and bcd are scrambled while busy and must be ignored.
    task automatic run_conv(input logic [15:0] b, input logic [15:0] eb,
                            input logic ee, input bit junk, input string name);
        int done_k;
        int busy_n;
        done_k = -1;
        busy_n = 0;
        @(negedge clk);
        start = 1'b1;
        bcd   = b;
        for (int k = 0; k < 40 && done_k < 0; k++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (k == 5 && !ee) check({name, " bin held while busy"}, bin, last_bin);
            if (done) begin
                done_k = k;
                start  = 1'b0;
                check({name, " bin"}, bin, eb);
                check({name, " err"}, err, ee);
            end else if (junk && k < 14) begin
                start = 1'($urandom_range(0, 1));
                bcd   = 16'($urandom_range(0, 65535));
            end else begin
                start = 1'b0;
                bcd   = b;
            end
        end
        check({name, " done latency"}, done_k, ee ? 0 : 16);
        check({name, " busy cycles"}, busy_n, ee ? 0 : 16);
        @(negedge clk);
        check({name, " done one cycle"}, done, 1'b0);
        if (done_k >= 0) last_bin = eb;
    endtask

    // stimulus
    initial begin
        int dk[3];
        int idx;
        int idle_n;
        int done_n;
        logic [15:0] b2b_exp[3];
        logic [15:0] b2b_in[3];

        tests    = 0;
        fails    = 0;
        last_bin = 16'h0;
        rst   = 1'b1;
        start = 1'b0;
        bcd   = 16'h0;

        vecs[0]  = '{16'h9999, 16'h270F, 1'b0};
        vecs[1]  = '{16'h12A4, 16'h0000, 1'b1};
        vecs[2]  = '{16'h1234, 16'h04D2, 1'b0};
        vecs[3]  = '{16'h0000, 16'h0000, 1'b0};
        vecs[4]  = '{16'h0001, 16'h0001, 1'b0};
        vecs[5]  = '{16'h5000, 16'h1388, 1'b0};
        vecs[6]  = '{16'h0999, 16'h03E7, 1'b0};
        vecs[7]  = '{16'h9A00, 16'h0000, 1'b1};
        vecs[8]  = '{16'h8765, 16'h223D, 1'b0};
        vecs[9]  = '{16'hF000, 16'h0000, 1'b1};
        vecs[10] = '{16'h0809, 16'h0329, 1'b0};
        vecs[11] = '{16'h000A, 16'h0000, 1'b1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset bin", bin, 16'h0);
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset err", err, 1'b0);
        check("reset state", state_dbg, 2'd0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_conv(vecs[i].bcd, vecs[i].bin, vecs[i].err, (i % 2) == 0,
                     $sformatf("vec%0d", i));
        end

        // back-to-back with start held high
        b2b_in[0] = 16'h0001; b2b_exp[0] = 16'd1;
        b2b_in[1] = 16'h0010; b2b_exp[1] = 16'd10;
        b2b_in[2] = 16'h0100; b2b_exp[2] = 16'd100;
        idx    = 0;
        idle_n = 0;
        dk[0] = -1; dk[1] = -1; dk[2] = -1;
        @(negedge clk);
        start = 1'b1;
        bcd   = b2b_in[0];
        for (int k = 0; k < 80 && idx < 3; k++) begin
            @(negedge clk);
            if (done) begin
                dk[idx] = k;
                check($sformatf("b2b%0d bin", idx), bin, b2b_exp[idx]);
                check($sformatf("b2b%0d err", idx), err, 1'b0);
                idx++;
                if (idx < 3) bcd = b2b_in[idx];
                else start = 1'b0;
            end else if (!busy) begin
                idle_n++;
            end
        end
        check("b2b done0 pos", dk[0], 16);
        check("b2b done1 pos", dk[1], 33);
        check("b2b done2 pos", dk[2], 50);
        check("b2b idle gap", idle_n, 0);
        last_bin = 16'd100;
        @(negedge clk);

        // reset in the 8th SHIFT cycle
        run_conv(16'h0042, 16'h002A, 1'b0, 1'b0, "pre-reset");
        @(negedge clk);
        start = 1'b1;
        bcd   = 16'h9999;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 7) begin
                check("mid-shift busy", busy, 1'b1);
                rst = 1'b1;
            end
        end
        @(negedge clk);
        check("abort bin", bin, 16'h0);
        check("abort busy", busy, 1'b0);
        check("abort done", done, 1'b0);
        check("abort err", err, 1'b0);
        check("abort state", state_dbg, 2'd0);
        rst = 1'b0;
        done_n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done || busy) done_n++;
        end
        check("abort no done", done_n, 0);
        last_bin = 16'h0;
        run_conv(16'h1234, 16'h04D2, 1'b0, 1'b0, "post-reset");

        // loopback against a bench-side binary-to-BCD model
        run_conv(to_bcd(0), 16'd0, 1'b0, 1'b0, "loop 0");
        run_conv(to_bcd(9999), 16'd9999, 1'b0, 1'b0, "loop 9999");
        for (int i = 0; i < 250; i++) begin
            int v;
            v = $urandom_range(0, 9999);
            run_conv(to_bcd(v), 16'(v), 1'b0, 1'b0, $sformatf("loop %0d", v));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
